ternary_act_skew_feeder: RTL and testbench
==========================================

# ternary_act_skew_feeder

Upstream feeder for the pipelined ternary systolic array (2-cycle MAC per PE). It accepts one activation vector per cycle through a valid/ready handshake and applies a per-row diagonal skew of 2·r cycles, so that each row's activation meets the partial sum arriving from the row above. It drives the array's global `enable` and `clear`. After the last vector it runs an automatic zero-fill drain that flushes every result out of the array's south edge.

## Interface
Parameters:
- ARRAY_SIZE, 64, rows in the array; also the number of skew lines.
- ACT_BITS, 16, signed activation width.
- CNT_BITS, 16, width of the vector counter.
- Derived constant DRAIN_CYCLES = 4·ARRAY_SIZE − 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a job; sampled only in IDLE.
- in_valid  in  1  in_act/in_last valid.
- in_ready  out  1  feeder accepts a vector; combinational, high only in STREAM.
- in_last  in  1  marks the final vector of the job; qualified by in_valid & in_ready.
- in_act  in  ARRAY_SIZE×ACT_BITS  signed activation vector; element r goes to row r.
- arr_enable  out  1  registered; drives the array `enable`.
- arr_clear  out  1  registered; drives the array `clear`.
- arr_act  out  ARRAY_SIZE×ACT_BITS  registered skewed activations; drive the array `act_in`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of the job.
- vec_count  out  CNT_BITS  vectors accepted in the current job.

## Operation
Control FSM:
- IDLE: start=1 → CLEAR.
- CLEAR: lasts one cycle. arr_clear=1 and all skew registers are zeroed. Always goes to STREAM.
- STREAM: in_ready=1. When in_valid & in_last, go to DRAIN.
- DRAIN: counts DRAIN_CYCLES advance beats, then goes to DONE.
- DONE: lasts one cycle with done=1, then returns to IDLE.

Advance signal: adv = (STREAM & in_valid) | DRAIN. adv is the only condition that shifts the skew lines. When adv=0 every skew register holds, so a stall in STREAM freezes the array and the skew lines together.

Skew lines:
- Row r is a shift register of 2r+1 stages; arr_act[r] is the last stage.
- The head loads in_act[r] in STREAM and 0 in DRAIN.
- Row 0 therefore has a 1-stage delay and row ARRAY_SIZE−1 has 2·ARRAY_SIZE−1 stages.

Registered outputs:
- arr_enable ← adv, so the array sees exactly one enable per advance beat and in the same cycle as the shifted data.
- arr_clear ← (next state == CLEAR).

Counters:
- vec_count is reset to 0 in CLEAR and increments on each accepted vector, wrapping modulo 2^CNT_BITS.
- vec_count holds its value through DRAIN, DONE and IDLE until the next job starts.
- The drain counter is $clog2(DRAIN_CYCLES+1) bits wide and increments on DRAIN cycles only.

Boundary behaviour:
- A job with a single vector (in_last on the first beat) is legal.
- start outside IDLE is ignored.
- in_valid outside STREAM is ignored; in_ready=0 there and no vector is consumed.
- in_last without in_valid has no effect.
- Asserting rst_n mid-job returns the block to IDLE and zeros all registers and outputs asynchronously.
- Arithmetic: pure delay; values pass through bit-exact with no sign or width change.

## Timing
- Reset values: in_ready=0, arr_enable=0, arr_clear=0, arr_act=all 0, busy=0, done=0, vec_count=0.
- start sampled at edge E: busy=1 and arr_clear=1 during cycle E+1 (CLEAR). in_ready=1 from cycle E+2.
- Vector k accepted at edge A:
  - arr_act[0] = in_act[0] and arr_enable=1 during cycle A+1.
  - arr_act[r] carries it after 2r further advance beats.
- DRAIN spans DRAIN_CYCLES cycles with arr_enable=1 throughout; done is high in the cycle after the final drain beat.
- With no stalls, a job of V vectors occupies 1 (CLEAR) + V + DRAIN_CYCLES + 1 (DONE) cycles of busy.

## Test plan
All scenarios use ARRAY_SIZE=4, so DRAIN_CYCLES=14.
- Reset: hold rst_n=0 while driving random inputs → every output is 0, in_ready=0, FSM in IDLE.
- Single vector {1,2,3,4}, in_last=1: arr_clear pulses once; row r shows value r+1 exactly 2r cycles after row 0; 14 drain cycles follow; done pulses once; vec_count=1.
- Back-to-back vectors 10, 20, 30 on every row, no stalls: arr_act[3] shows 10, 20, 30 on consecutive cycles starting 7 cycles after acceptance; arr_enable stays continuously high.
- Stall: drop in_valid for 3 cycles mid-stream → arr_enable=0 for those 3 cycles, arr_act holds its values, and the skew relationship is unchanged afterwards.
- Negative values: −32768 and −1 emerge bit-exact on all rows; zeros fill in behind them during DRAIN.
- rst_n asserted during DRAIN → all outputs 0 immediately and no done pulse; a fresh start afterwards completes normally with vec_count counting from 0.

Source files
------------

// File: rtl/ternary_act_skew_feeder.sv
// Activation feeder for the pipelined ternary systolic array: per-row 2r diagonal skew,
// array enable/clear generation and an automatic zero-fill drain after the last vector.
module ternary_act_skew_feeder #(
  parameter int ARRAY_SIZE = 64,
  parameter int ACT_BITS   = 16,
  parameter int CNT_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [ARRAY_SIZE*ACT_BITS-1:0] in_act,
  output logic                           arr_enable,
  output logic                           arr_clear,
  output logic [ARRAY_SIZE*ACT_BITS-1:0] arr_act,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_BITS-1:0]            vec_count
);

  localparam int DRAIN_CYCLES = 4 * ARRAY_SIZE - 2;
  localparam int DC_BITS      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DC_BITS-1:0] DRAIN_LAST = DC_BITS'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [DC_BITS-1:0] drain_cnt;
  logic               adv;

  assign in_ready = (state == S_STREAM);
  // Only an accepted vector or a drain beat moves the skew lines and the array.
  assign adv      = (in_ready && in_valid) || (state == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      drain_cnt  <= '0;
      vec_count  <= '0;
      arr_enable <= 1'b0;
      arr_clear  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      arr_enable <= adv;
      arr_clear  <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLEAR;
            arr_clear <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_CLEAR: begin
          state     <= S_STREAM;
          vec_count <= '0;
        end
        S_STREAM: begin
          if (in_valid) begin
            vec_count <= vec_count + CNT_BITS'(1);
            if (in_last) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DC_BITS'(1);
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Row r delays by 2r+1 advance beats so it meets the partial sum from the row above.
  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
    localparam int STAGES = 2 * r + 1;
    logic [ACT_BITS-1:0] line [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < STAGES; i++) line[i] <= '0;
      end else if (state == S_CLEAR) begin
        for (int i = 0; i < STAGES; i++) line[i] <= '0;
      end else if (adv) begin
        line[0] <= (state == S_STREAM) ? in_act[r*ACT_BITS +: ACT_BITS] : '0;
        for (int i = 1; i < STAGES; i++) line[i] <= line[i-1];
      end
    end

    assign arr_act[r*ACT_BITS +: ACT_BITS] = line[STAGES-1];
  end

endmodule

// File: tb/tb_ternary_act_skew_feeder.sv
// Scoreboard bench for ternary_act_skew_feeder with ARRAY_SIZE=4 (14 drain beats).
module tb_ternary_act_skew_feeder;
  localparam int N  = 4;
  localparam int B  = 16;
  localparam int W  = N * B;
  localparam int DC = 4 * N - 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [W-1:0] in_act = '0;
  logic         in_ready, arr_enable, arr_clear, busy, done;
  logic [W-1:0] arr_act;
  logic [15:0]  vec_count;

  ternary_act_skew_feeder #(.ARRAY_SIZE(N), .ACT_BITS(B), .CNT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_act(in_act), .arr_enable(arr_enable), .arr_clear(arr_clear),
    .arr_act(arr_act), .busy(busy), .done(done), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int clr_cnt = 0, done_cnt = 0, busy_cnt = 0, en_cnt = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] vecs  [$];
  logic [20:0]  ctl;

  assign ctl = {in_ready, arr_enable, arr_clear, busy, done, vec_count};

  function automatic logic [W-1:0] mk(input logic [B-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance beat j shows vector j-2r on row r, zeros before the job and behind it.
  task automatic build_exp();
    int v;
    logic [W-1:0] e, t;
    v = vecs.size();
    for (int j = 0; j < v + DC; j++) begin
      e = '0;
      for (int r = 0; r < N; r++) begin
        if (j - 2*r >= 0 && j - 2*r < v) begin
          t = vecs[j - 2*r];
          e[r*B +: B] = t[r*B +: B];
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every enable beat is one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (arr_clear) clr_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (arr_enable) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %h expected no enable", arr_act);
        end else begin
          check("arr_act", arr_act, exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_job(input int stall_at, input int stall_len, input string tag);
    int v;
    logic [W-1:0] held;
    v = vecs.size();
    build_exp();
    clr_cnt = 0; done_cnt = 0; busy_cnt = 0; en_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    // CLEAR cycle; a valid vector here must be ignored
    start = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_act = {32'hdead_beef, 32'hcafe_f00d};
    check({tag, "_clear_ctl"}, W'({in_ready, arr_clear, busy}), W'(3'b011));
    @(negedge clk);
    check({tag, "_stream_rdy"}, W'(in_ready), W'(1));
    for (int k = 0; k < v; k++) begin
      if (k == stall_at) begin
        in_valid = 1'b0; in_last = 1'b1; start = 1'b1;
        held = arr_act;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check({tag, "_stall_en"}, W'(arr_enable), W'(0));
          check({tag, "_stall_hold"}, arr_act, held);
        end
        in_last = 1'b0; start = 1'b0;
      end
      in_act = vecs[k]; in_valid = 1'b1; in_last = (k == v - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; in_act = {$urandom(), $urandom()};
    for (int t = 0; t < 100 && !done; t++) @(negedge clk);
    check({tag, "_done_seen"}, W'(done), W'(1));
    @(negedge clk);
    #1;
    check({tag, "_vec_count"}, W'(vec_count), W'(v));
    check({tag, "_clr_pulses"}, W'(clr_cnt), W'(1));
    check({tag, "_done_pulses"}, W'(done_cnt), W'(1));
    check({tag, "_en_beats"}, W'(en_cnt), W'(v + DC));
    check({tag, "_busy_cycles"}, W'(busy_cnt), W'(v + stall_len + DC + 2));
    check({tag, "_sb_empty"}, W'(exp_q.size()), W'(0));
    check({tag, "_idle_busy"}, W'(busy), W'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom()); in_valid = 1'($urandom()); in_last = 1'($urandom());
      in_act = {$urandom(), $urandom()};
      @(negedge clk);
      check("rst_act", arr_act, '0);
      check("rst_ctl", W'(ctl), '0);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    vecs.delete();
    vecs.push_back(mk(16'd1, 16'd2, 16'd3, 16'd4));
    run_job(-1, 0, "single");

    vecs.delete();
    vecs.push_back(mk(16'd10, 16'd10, 16'd10, 16'd10));
    vecs.push_back(mk(16'd20, 16'd20, 16'd20, 16'd20));
    vecs.push_back(mk(16'd30, 16'd30, 16'd30, 16'd30));
    run_job(-1, 0, "b2b");

    vecs.delete();
    vecs.push_back(mk(16'd1, 16'd2, 16'd3, 16'd4));
    vecs.push_back(mk(16'd5, 16'd6, 16'd7, 16'd8));
    vecs.push_back(mk(16'd9, 16'd10, 16'd11, 16'd12));
    vecs.push_back(mk(16'd13, 16'd14, 16'd15, 16'd16));
    run_job(2, 3, "stall");

    vecs.delete();
    vecs.push_back(mk(16'h8000, 16'hffff, 16'h8000, 16'hffff));
    vecs.push_back(mk(16'hffff, 16'h8000, 16'hffff, 16'h8000));
    run_job(-1, 0, "neg");

    // Reset in the middle of DRAIN
    vecs.delete();
    vecs.push_back(mk(16'd5, 16'd6, 16'd7, 16'd8));
    build_exp();
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_act = vecs[0]; in_valid = 1'b1; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_busy", W'(busy), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_act", arr_act, '0);
    check("midrst_ctl", W'(ctl), '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_done", W'(done_cnt), W'(0));
    check("midrst_idle", W'(busy), W'(0));

    vecs.delete();
    vecs.push_back(mk(16'd100, 16'd200, 16'd300, 16'd400));
    vecs.push_back(mk(16'h7fff, 16'h0001, 16'hfffe, 16'h1234));
    run_job(-1, 0, "fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
